// File: rtl/sr_ff_sequencer.sv
// Drives registered S/R excitation for a bank of external SR flip-flops so it
// behaves as D, T or JK, with a forced-hold settle window after each mode change.
module sr_ff_sequencer #(
  parameter int W      = 1,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [1:0]   cfg_mode,
  output logic         cfg_ready,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] s,
  output logic [W-1:0] r,
  output logic [1:0]   mode,
  output logic         busy,
  output logic         err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [1:0] MODE_D    = 2'b00;
  localparam logic [1:0] MODE_T    = 2'b01;
  localparam logic [1:0] MODE_JK   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic         accept;
  logic         legal;
  logic [W-1:0] s_next;
  logic [W-1:0] r_next;

  assign cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = (cfg_mode != MODE_RSVD);
  assign busy      = (state == ST_SWITCH);

  // Only the inputs of the active mode are selected, so unused ones cannot leak into s/r.
  always_comb begin
    s_next = '0;
    r_next = '0;
    if (state == ST_RUN && !(accept && legal) && en) begin
      case (mode)
        MODE_D: begin
          s_next = d;
          r_next = ~d;
        end
        MODE_T: begin
          s_next = d & ~q_fb;
          r_next = d & q_fb;
        end
        MODE_JK: begin
          s_next = j & ~q_fb;
          r_next = k & q_fb;
        end
        default: begin
          s_next = '0;
          r_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mode  <= MODE_D;
      cnt   <= '0;
      s     <= '0;
      r     <= '0;
      err   <= 1'b0;
    end else begin
      s   <= s_next;
      r   <= r_next;
      err <= accept & ~legal;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept && legal) begin
            state <= ST_SWITCH;
            mode  <= cfg_mode;
            cnt   <= SETTLE_LAST;
          end
        end
        ST_SWITCH: begin
          if (cnt == '0) state <= ST_RUN;
          else           cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_sequencer.sv
// Directed bench for sr_ff_sequencer: one instance with SETTLE=1 driving a
// behavioural SR bank, and a SETTLE=3 instance for settle length and async reset.
module tb_sr_ff_sequencer;

  localparam int W = 4;

  logic         clk = 1'b1;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         en = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q_dir = '0;
  logic         loop = 1'b0;
  logic [W-1:0] q_bank;
  logic [W-1:0] q_fb;

  logic         cfg_ready, busy, err;
  logic [W-1:0] s, r;
  logic [1:0]   mode;
  logic         cfg_ready3, busy3, err3;
  logic [W-1:0] s3, r3;
  logic [1:0]   mode3;

  int checks = 0;
  int passes = 0;

  assign q_fb = loop ? q_bank : q_dir;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) q_bank <= '0;
    else     q_bank <= s | (q_bank & ~r);
  end

  sr_ff_sequencer #(.W(W), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_ready(cfg_ready), .en(en), .d(d), .j(j), .k(k), .q_fb(q_fb),
    .s(s), .r(r), .mode(mode), .busy(busy), .err(err)
  );

  sr_ff_sequencer #(.W(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_ready(cfg_ready3), .en(en), .d(d), .j(j), .k(k), .q_fb(q_fb),
    .s(s3), .r(r3), .mode(mode3), .busy(busy3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_s, exp_r;

    #2;
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cfg_ready, 1);
    #13;
    rst = 1'b0;
    en  = 1'b1;
    d   = 4'hF;
    step(2);
    chk("idle_s", s, 0);
    chk("idle_r", r, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cfg_ready, 1);

    cfg_valid = 1'b1; cfg_mode = 2'b11;
    step();
    chk("idle_ill_err", err, 1);
    chk("idle_ill_mode", mode, 0);
    chk("idle_ill_busy", busy, 0);
    chk("idle_ill_ready", cfg_ready, 1);
    cfg_valid = 1'b0;
    step();
    chk("idle_ill_err_end", err, 0);

    // D mode, unused inputs undriven-ish
    j = 'x; k = 'x; q_dir = 'x;
    cfg_valid = 1'b1; cfg_mode = 2'b00; d = 4'h0;
    step();
    chk("d_sw_busy", busy, 1);
    chk("d_sw_s", s, 0);
    chk("d_sw_r", r, 0);
    chk("d_sw_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    step();
    chk("d_enter_busy", busy, 0);
    chk("d_enter_s", s, 0);
    chk("d_enter_ready", cfg_ready, 1);
    step();
    chk("d0_s", s, 4'h0);
    chk("d0_r", r, 4'hF);
    d = 4'h5;
    step();
    chk("d5_s", s, 4'h5);
    chk("d5_r", r, 4'hA);
    d = 4'hF;
    step();
    chk("dF_s", s, 4'hF);
    chk("dF_r", r, 4'h0);
    d = 4'h0;
    step();
    chk("d0b_r", r, 4'hF);
    en = 1'b0;
    step();
    chk("en0_s", s, 0);
    chk("en0_r", r, 0);

    // T mode with the bank looped back
    j = '0; k = '0; q_dir = '0; loop = 1'b1;
    d = 4'hF; en = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'b01;
    step();
    chk("t_sw_busy", busy, 1);
    chk("t_sw_mode", mode, 1);
    cfg_valid = 1'b0;
    step();
    chk("t_enter_s", s, 0);
    step();
    chk("t_e3_s", s, 4'hF);
    chk("t_e3_q", q_bank, 4'h0);
    step();
    chk("t_e4_q", q_bank, 4'hF);
    chk("t_e4_s", s, 4'hF);
    step();
    chk("t_e5_q", q_bank, 4'hF);
    chk("t_e5_r", r, 4'hF);
    chk("t_e5_s", s, 4'h0);
    step();
    chk("t_e6_q", q_bank, 4'h0);
    step();
    chk("t_e7_q", q_bank, 4'h0);
    step();
    chk("t_e8_q", q_bank, 4'hF);
    step();
    chk("t_e9_q", q_bank, 4'hF);
    d = 4'h0;
    step();
    chk("t_hold1_q", q_bank, 4'h0);
    step();
    chk("t_hold2_q", q_bank, 4'h0);
    chk("t_hold_s", s, 0);
    chk("t_hold_r", r, 0);

    // JK mode with directed feedback
    loop = 1'b0; q_dir = 4'b0011; j = 4'b1010; k = 4'b0110;
    cfg_valid = 1'b1; cfg_mode = 2'b10;
    step();
    chk("jk_sw_busy", busy, 1);
    chk("jk_sw_mode", mode, 2);
    cfg_valid = 1'b0;
    step();
    chk("jk_enter_s", s, 0);
    step();
    chk("jk_s", s, 4'b1000);
    chk("jk_r", r, 4'b0010);
    for (int i = 0; i < 1000; i++) begin
      j     = 4'($urandom);
      k     = 4'($urandom);
      q_dir = 4'($urandom);
      en    = 1'($urandom);
      exp_s = en ? (j & ~q_dir) : '0;
      exp_r = en ? (k & q_dir) : '0;
      step();
      chk("jk_excl", s & r, 0);
      chk("jk_rand_s", s, exp_s);
      chk("jk_rand_r", r, exp_r);
    end

    // illegal config in RUN(D), then accept-over-en priority
    en = 1'b1; d = 4'hF; cfg_valid = 1'b1; cfg_mode = 2'b00;
    step();
    cfg_valid = 1'b0;
    step(2);
    chk("run_d_s", s, 4'hF);
    cfg_valid = 1'b1; cfg_mode = 2'b11; d = 4'h0;
    step();
    chk("ill_err", err, 1);
    chk("ill_mode", mode, 0);
    chk("ill_busy", busy, 0);
    chk("ill_s", s, 4'h0);
    chk("ill_r", r, 4'hF);
    cfg_valid = 1'b0; d = 4'hF;
    step();
    chk("ill_err_end", err, 0);
    chk("ill_cont_s", s, 4'hF);
    cfg_valid = 1'b1; cfg_mode = 2'b00; d = 4'h0;
    step();
    chk("prio_busy", busy, 1);
    chk("prio_s", s, 0);
    chk("prio_r", r, 0);
    cfg_valid = 1'b0;
    step(2);

    // async reset in the middle of a 3-cycle settle window
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    q_dir = 4'h0; d = 4'hF; en = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'b01;
    step();
    chk("s3_busy_a", busy3, 1);
    cfg_valid = 1'b0;
    step();
    chk("s3_busy_b", busy3, 1);
    chk("s1_busy_b", busy, 0);
    step();
    chk("s3_busy_c", busy3, 1);
    chk("s3_mode_c", mode3, 1);
    chk("s1_run_s", s, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy3", busy3, 0);
    chk("arst_s3", s3, 0);
    chk("arst_r3", r3, 0);
    chk("arst_mode3", mode3, 0);
    chk("arst_ready3", cfg_ready3, 1);
    chk("arst_s", s, 0);
    chk("arst_busy", busy, 0);
    #2;
    rst = 1'b0;
    step();
    chk("post_busy3", busy3, 0);
    chk("post_s3", s3, 0);
    chk("post_s", s, 0);
    chk("post_ready3", cfg_ready3, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
